// File: rtl/restoring_divider_pkg.sv
// restoring_divider_pkg
//   Shared definitions for the restoring divider slice: the controller state
//   encoding (2-bit) and the default operand width.
//   Imported by restoring_divider and its interface.
package restoring_divider_pkg;

    localparam int DIV_WIDTH_DEFAULT = 32;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_RUN  = 2'd1,
        DIV_FIX  = 2'd2,
        DIV_DONE = 2'd3
    } div_state_t;

endpackage

// File: rtl/restoring_divider_if.sv
// restoring_divider_if
//   Request/result bundle between the ALU (master) and the divider (slave).
//   master drives : start, is_signed, dividend, divisor
//   slave drives  : busy, done, quotient, remainder, div_by_zero
interface restoring_divider_if
    import restoring_divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
);
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, is_signed, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, is_signed, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/restoring_divider_adder.sv
// restoring_divider_adder
//   Plain n-bit ripple-carry adder: o_sum = i_a + i_b + i_c_in.
//   The divider drives i_b with an inverted operand and i_c_in = 1 to subtract;
//   o_c_out = 1 then means "no borrow".
//   Ports: i_a, i_b (n bits), i_c_in -> o_sum (n bits), o_c_out.
module restoring_divider_adder #(
    parameter int n = 33
) (
    input  logic [n-1:0] i_a,
    input  logic [n-1:0] i_b,
    input  logic         i_c_in,
    output logic [n-1:0] o_sum,
    output logic         o_c_out
);
    logic [n:0] w_carry;

    assign w_carry[0] = i_c_in;

    generate
        for (genvar gi = 0; gi < n; gi++) begin : g_bit
            assign o_sum[gi]       = i_a[gi] ^ i_b[gi] ^ w_carry[gi];
            assign w_carry[gi + 1] = (i_a[gi] & i_b[gi]) | (w_carry[gi] & (i_a[gi] ^ i_b[gi]));
        end
    endgenerate

    assign o_c_out = w_carry[n];
endmodule

// File: rtl/restoring_divider.sv
// restoring_divider
//   Multi-cycle shift-and-subtract integer divider for DIV/DIVU/REM/REMU.
//   One quotient bit per cycle; the single ripple adder is the only arithmetic
//   element in the iteration path.
//   Ports: clk, reset_n (synchronous, active-low),
//          bus (restoring_divider_if.slave): start, is_signed, dividend,
//          divisor in; busy, done, quotient, remainder, div_by_zero out.
//   Optional feature macro: SIGNED_DIV_EN (two's-complement operands with a
//   FIX cycle for sign correction). Undefined: is_signed is ignored.
module restoring_divider
    import restoring_divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset_n,
    restoring_divider_if.slave   bus
);
    localparam int CW = $clog2(WIDTH);

    div_state_t       r_state, w_state_next;
    logic [WIDTH-1:0] r_rem;          // partial remainder; always < divisor, so WIDTH bits suffice
    logic [WIDTH-1:0] r_q;            // dividend shifting out / quotient shifting in
    logic [WIDTH-1:0] r_divisor;
    logic [CW-1:0]    r_count;
    logic             r_busy, r_done, r_div_by_zero;
    logic [WIDTH-1:0] r_quotient, r_remainder;

    logic [WIDTH:0]   w_shifted;
    logic [WIDTH:0]   w_add_a, w_add_b, w_sum;
    logic             w_c_out;
    logic [WIDTH-1:0] w_rem_next, w_q_next;
    logic             w_div_zero;
    logic             w_unused;

`ifdef SIGNED_DIV_EN
    logic r_q_neg, r_r_neg;
    logic w_dvd_neg, w_dvs_neg;

    function automatic logic [WIDTH-1:0] f_neg(input logic [WIDTH-1:0] x);
        return ~x + WIDTH'(1);
    endfunction

    assign w_dvd_neg = bus.is_signed & bus.dividend[WIDTH-1];
    assign w_dvs_neg = bus.is_signed & bus.divisor[WIDTH-1];
    assign w_unused  = w_sum[WIDTH];
`else
    assign w_unused  = w_sum[WIDTH] ^ bus.is_signed;
`endif

    assign w_div_zero = (bus.divisor == '0);
    assign w_shifted  = {r_rem, r_q[WIDTH-1]};

    // In FIX the adder computes 0 - quotient; otherwise it is the trial subtract.
    always_comb begin
        if (r_state == DIV_FIX) begin
            w_add_a = '0;
            w_add_b = ~{1'b0, r_q};
        end else begin
            w_add_a = w_shifted;
            w_add_b = ~{1'b0, r_divisor};
        end
    end

    restoring_divider_adder #(.n(WIDTH + 1)) u_adder (
        .i_a     (w_add_a),
        .i_b     (w_add_b),
        .i_c_in  (1'b1),
        .o_sum   (w_sum),
        .o_c_out (w_c_out)
    );

    // On borrow the shifted value is < divisor, so its top bit is zero.
    assign w_rem_next = w_c_out ? w_sum[WIDTH-1:0] : w_shifted[WIDTH-1:0];
    assign w_q_next   = {r_q[WIDTH-2:0], w_c_out};

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            DIV_IDLE: if (bus.start) w_state_next = w_div_zero ? DIV_DONE : DIV_RUN;
`ifdef SIGNED_DIV_EN
            DIV_RUN:  if (r_count == '0) w_state_next = DIV_FIX;
`else
            DIV_RUN:  if (r_count == '0) w_state_next = DIV_DONE;
`endif
            DIV_FIX:  w_state_next = DIV_DONE;
            DIV_DONE: w_state_next = DIV_IDLE;
            default:  w_state_next = DIV_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state       <= DIV_IDLE;
            r_rem         <= '0;
            r_q           <= '0;
            r_divisor     <= '0;
            r_count       <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_div_by_zero <= 1'b0;
            r_quotient    <= '0;
            r_remainder   <= '0;
`ifdef SIGNED_DIV_EN
            r_q_neg       <= 1'b0;
            r_r_neg       <= 1'b0;
`endif
        end else begin
            r_state <= w_state_next;
            r_busy  <= (w_state_next == DIV_RUN);
            r_done  <= (w_state_next == DIV_DONE);
            case (r_state)
                DIV_IDLE: begin
                    if (bus.start) begin
                        r_rem         <= '0;
                        r_count       <= CW'(WIDTH - 1);
                        r_div_by_zero <= w_div_zero;
`ifdef SIGNED_DIV_EN
                        r_q       <= w_dvd_neg ? f_neg(bus.dividend) : bus.dividend;
                        r_divisor <= w_dvs_neg ? f_neg(bus.divisor) : bus.divisor;
                        r_q_neg   <= w_dvd_neg ^ w_dvs_neg;
                        r_r_neg   <= w_dvd_neg;
`else
                        r_q       <= bus.dividend;
                        r_divisor <= bus.divisor;
`endif
                        // Divide by zero goes straight to DONE with the raw dividend.
                        if (w_div_zero) begin
                            r_quotient  <= '1;
                            r_remainder <= bus.dividend;
                        end
                    end
                end
                DIV_RUN: begin
                    r_rem   <= w_rem_next;
                    r_q     <= w_q_next;
                    r_count <= r_count - CW'(1);
`ifndef SIGNED_DIV_EN
                    if (r_count == '0) begin
                        r_quotient  <= w_q_next;
                        r_remainder <= w_rem_next;
                    end
`endif
                end
`ifdef SIGNED_DIV_EN
                DIV_FIX: begin
                    r_quotient  <= r_q_neg ? w_sum[WIDTH-1:0] : r_q;
                    r_remainder <= r_r_neg ? f_neg(r_rem) : r_rem;
                end
`endif
                default: ;
            endcase
        end
    end

    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.quotient    = r_quotient;
    assign bus.remainder   = r_remainder;
    assign bus.div_by_zero = r_div_by_zero;
endmodule

// File: tb/tb_restoring_divider.sv
module tb_restoring_divider;
    localparam int W = 32;
`ifdef SIGNED_DIV_EN
    localparam bit SIGNED_BUILD = 1'b1;
`else
    localparam bit SIGNED_BUILD = 1'b0;
`endif
    localparam int LAT = SIGNED_BUILD ? W + 2 : W + 1;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    restoring_divider_if #(.WIDTH(W)) bus ();

    restoring_divider #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         s;
        logic [W-1:0] eq;
        logic [W-1:0] er;
        logic         edbz;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, got, exp);
        end
    endtask

    // Reference: plain arithmetic from the operand rules.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         output logic [W-1:0] q, output logic [W-1:0] r, output logic dbz);
        longint la, lb, lq, lr;
        dbz = 1'b0;
        if (b == '0) begin
            q = '1; r = a; dbz = 1'b1;
        end else if (SIGNED_BUILD && s) begin
            la = longint'($signed(a));
            lb = longint'($signed(b));
            lq = la / lb;
            lr = la % lb;
            q = lq[W-1:0];
            r = lr[W-1:0];
        end else begin
            q = a / b;
            r = a % b;
        end
    endtask

    // Issue one request; optionally re-assert start with other operands at
    // the edge inj_k. Observes done/busy for a bounded window.
    task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                           input int inj_k, input logic [W-1:0] ia, input logic [W-1:0] ib,
                           output logic [W-1:0] q, output logic [W-1:0] r, output logic dbz,
                           output int done_k, output int n_done, output int n_busy);
        q = '0; r = '0; dbz = 1'b0; done_k = -1; n_done = 0; n_busy = 0;
        @(negedge clk);
        bus.start = 1'b1; bus.dividend = a; bus.divisor = b; bus.is_signed = s;
        @(posedge clk);
        #1 bus.start = 1'b0;
        for (int k = 1; k <= W + 8; k++) begin
            @(negedge clk);
            if (k == inj_k) begin
                bus.start = 1'b1; bus.dividend = ia; bus.divisor = ib;
            end else begin
                bus.start = 1'b0;
            end
            if (bus.busy) n_busy++;
            if (bus.done) begin
                n_done++;
                if (done_k < 0) begin
                    done_k = k; q = bus.quotient; r = bus.remainder; dbz = bus.div_by_zero;
                end
            end
        end
        bus.start = 1'b0;
    endtask

    task automatic txn(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic s, input logic [W-1:0] eq, input logic [W-1:0] er,
                       input logic edbz, input int inj_k, input logic [W-1:0] ia,
                       input logic [W-1:0] ib);
        logic [W-1:0] q, r;
        logic dbz;
        int dk, nd, nb;
        run_div(a, b, s, inj_k, ia, ib, q, r, dbz, dk, nd, nb);
        $display("%s: %h / %h signed=%0d -> q=%h r=%h dbz=%0d done@%0d busy=%0d",
                 tag, a, b, s, q, r, dbz, dk, nb);
        check({tag, " quotient"}, q, eq);
        check({tag, " remainder"}, r, er);
        check({tag, " div_by_zero"}, W'(dbz), W'(edbz));
        check({tag, " done edge"}, W'(dk), edbz ? W'(1) : W'(LAT));
        check({tag, " done pulses"}, W'(nd), W'(1));
        check({tag, " busy cycles"}, W'(nb), edbz ? W'(0) : W'(W));
        check({tag, " held quotient"}, bus.quotient, eq);
    endtask

    initial begin
        logic [W-1:0] a, b, eq, er;
        logic s, edbz;
        int nd;

        vecs[0]  = '{32'd100,       32'd7,          1'b0, 32'd14,        32'd2,        1'b0};
        vecs[1]  = '{32'd5,         32'd0,          1'b0, 32'hFFFFFFFF,  32'd5,        1'b1};
        vecs[2]  = '{32'hFFFFFFFF,  32'd1,          1'b0, 32'hFFFFFFFF,  32'd0,        1'b0};
        vecs[3]  = '{32'd0,         32'd3,          1'b0, 32'd0,         32'd0,        1'b0};
        vecs[4]  = '{32'd3,         32'd5,          1'b0, 32'd0,         32'd3,        1'b0};
        vecs[5]  = '{32'hFFFFFFFF,  32'hFFFFFFFF,   1'b0, 32'd1,         32'd0,        1'b0};
        vecs[6]  = '{32'h80000000,  32'd2,          1'b0, 32'h40000000,  32'd0,        1'b0};
        vecs[10] = '{32'hFFFFFFF9,  32'd0,          1'b1, 32'hFFFFFFFF,  32'hFFFFFFF9, 1'b1};
`ifdef SIGNED_DIV_EN
        vecs[7]  = '{32'hFFFFFFF9,  32'd2,          1'b1, 32'hFFFFFFFD,  32'hFFFFFFFF, 1'b0};
        vecs[8]  = '{32'h80000000,  32'hFFFFFFFF,   1'b1, 32'h80000000,  32'd0,        1'b0};
        vecs[9]  = '{32'd7,         32'hFFFFFFFE,   1'b1, 32'hFFFFFFFD,  32'd1,        1'b0};
`else
        vecs[7]  = '{32'hFFFFFFF9,  32'd2,          1'b1, 32'h7FFFFFFC,  32'd1,        1'b0};
        vecs[8]  = '{32'h80000000,  32'hFFFFFFFF,   1'b1, 32'd0,         32'h80000000, 1'b0};
        vecs[9]  = '{32'd7,         32'hFFFFFFFE,   1'b1, 32'd0,         32'd7,        1'b0};
`endif

        bus.start = 1'b0; bus.is_signed = 1'b0; bus.dividend = '0; bus.divisor = '0;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset busy", W'(bus.busy), W'(0));
        check("reset done", W'(bus.done), W'(0));
        check("reset quotient", bus.quotient, '0);
        check("reset remainder", bus.remainder, '0);
        check("reset div_by_zero", W'(bus.div_by_zero), W'(0));
        reset_n = 1'b1;

        for (int i = 0; i < 11; i++)
            txn($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].s,
                vecs[i].eq, vecs[i].er, vecs[i].edbz, -1, '0, '0);

        // start while busy: second request must not disturb the first
        txn("busy_guard", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 5, 32'd50, 32'd3);
        // start while done is showing: ignored, no second run
        txn("done_guard", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, LAT, 32'd9, 32'd4);

        // reset in the middle of a divide
        @(negedge clk);
        bus.start = 1'b1; bus.dividend = 32'd1000; bus.divisor = 32'd9; bus.is_signed = 1'b0;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (10) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        $display("reset_mid: busy=%0d done=%0d q=%h r=%h", bus.busy, bus.done, bus.quotient, bus.remainder);
        check("reset_mid busy", W'(bus.busy), W'(0));
        check("reset_mid done", W'(bus.done), W'(0));
        check("reset_mid quotient", bus.quotient, '0);
        check("reset_mid remainder", bus.remainder, '0);
        reset_n = 1'b1;
        nd = 0;
        for (int k = 0; k < W + 6; k++) begin
            @(negedge clk);
            if (bus.done) nd++;
        end
        check("reset_mid no done", W'(nd), W'(0));
        txn("after_reset", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, -1, '0, '0);

        // randomized against the reference model
        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            b = (i % 10 == 3) ? '0 : ($urandom >> $urandom_range(0, 31));
            s = 1'($urandom_range(0, 1));
            model(a, b, s, eq, er, edbz);
            txn($sformatf("rnd%0d", i), a, b, s, eq, er, edbz, -1, '0, '0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
